// File: rtl/stream_frame_writer.sv
// Frame-buffer sink for the filtered pixel stream.
// Accepts pixels through a 2-entry FIFO and writes them in raster order
// through a registered write port that holds its request while the memory
// stalls. frame_start realigns the writer to address 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   x_data_i        pixel in, R[29:20] G[19:10] B[9:0]
//   x_valid_i       pixel valid
//   x_ready_o       pixel accept (registered)
//   frame_start_i   one-cycle frame alignment pulse
//   wr_en_o         frame-buffer write request
//   wr_addr_o       write address, row*WIDTH+col
//   wr_data_o       write data
//   wr_busy_i       memory stall; a write completes on wr_en_o && !wr_busy_i
//   frame_done_o    one-cycle pulse after the last pixel of a frame is written
//   sync_err_o      sticky: frame_start arrived mid-frame
module stream_frame_writer #(
    parameter int unsigned W      = 30,
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      x_data_i,
    input  logic              x_valid_i,
    output logic              x_ready_o,
    input  logic              frame_start_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [W-1:0]      wr_data_o,
    input  logic              wr_busy_i,
    output logic              frame_done_o,
    output logic              sync_err_o
);

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned LAST  = WIDTH * HEIGHT - 1;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        mem_q [2];
    logic [W-1:0]        mem_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]        wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                sync_err_q, sync_err_d;

    logic push_c, pop_c, resync_c, can_load_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            nxt_addr_q   <= '0;
            ready_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            nxt_addr_q   <= nxt_addr_d;
            ready_q      <= ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Next-state: FSM, FIFO, output stage and raster address counter
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        nxt_addr_d   = nxt_addr_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sync_err_d   = sync_err_q;

        push_c       = x_valid_i && ready_q;
        resync_c     = (state_q == ACTIVE) && frame_start_i;
        can_load_c   = (state_q == ACTIVE) && (!wr_en_q || !wr_busy_i);
        pop_c        = can_load_c && (cnt_q != 2'd0) && !resync_c;
        // Completion is judged on the memory side, independent of a resync.
        frame_done_d = wr_en_q && !wr_busy_i && (wr_addr_q == ADDR_W'(LAST));

        case (state_q)
            IDLE:    if (frame_start_i) state_d = ACTIVE;
            ACTIVE:  state_d = ACTIVE;
            default: state_d = IDLE;
        endcase

        if (resync_c) begin
            // Flush first, so a same-cycle pixel becomes pixel 0 of the new frame.
            if (nxt_addr_q != '0) sync_err_d = 1'b1;
            col_d      = '0;
            row_d      = '0;
            nxt_addr_d = '0;
            wr_en_d    = 1'b0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            cnt_d      = 2'd0;
            if (push_c) begin
                mem_d[0] = x_data_i;
                wr_ptr_d = 1'b1;
                cnt_d    = 2'd1;
            end
        end else begin
            if (can_load_c) begin
                if (pop_c) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
                    wr_addr_d = nxt_addr_q;
                    rd_ptr_d  = ~rd_ptr_q;
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(HEIGHT - 1)) begin
                            row_d      = '0;
                            nxt_addr_d = '0;
                        end else begin
                            row_d      = row_q + ROW_W'(1);
                            nxt_addr_d = nxt_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        col_d      = col_q + COL_W'(1);
                        nxt_addr_d = nxt_addr_q + ADDR_W'(1);
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            if (push_c) begin
                mem_d[wr_ptr_q] = x_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
        end

        // Registered ready tracks the next state, so it never depends on wr_busy_i combinationally.
        ready_d = (state_d == ACTIVE) && (cnt_d != 2'd2);
    end

    assign x_ready_o    = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_stream_frame_writer.sv
// Directed self-checking bench for stream_frame_writer.
module tb_stream_frame_writer;

    localparam int unsigned N = 320 * 240;

    logic        clk;
    logic        rst_n;
    logic [29:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic        frame_start;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [29:0] wr_data;
    logic        wr_busy;
    logic        frame_done;
    logic        sync_err;

    int n_chk;
    int n_fail;

    stream_frame_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_data_i     (x_data),
        .x_valid_i    (x_valid),
        .x_ready_o    (x_ready),
        .frame_start_i(frame_start),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_busy_i    (wr_busy),
        .frame_done_o (frame_done),
        .sync_err_o   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        vld;
        logic [29:0] data;
        logic        busy;
        logic        e_rdy;
        logic        e_en;
        logic [16:0] e_addr;
        logic [29:0] e_data;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pix(input int c);
        return 30'(c) ^ 30'h15555555;
    endfunction

    // Drive one pixel until it is accepted; returns 1 ns after the handshake edge.
    task automatic send_px(input logic [29:0] d);
        int t;
        t = 0;
        x_valid = 1'b1;
        x_data  = d;
        while (!x_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL px_accept_timeout: data 0x%0h not accepted within %0d cycles", d, t);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, done_cnt, done_at;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        x_data = '0;
        x_valid = 1'b0;
        frame_start = 1'b0;
        wr_busy = 1'b0;

        // Reset state
        #1;
        check("rst_ready", 32'(x_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        step();
        rst_n = 1'b1;

        // frame_start, 8 pixels back-to-back, then a 5-cycle stall
        vt[0]  = '{1'b1, 1'b0, 30'd0,  1'b0, 1'b1, 1'b0, 17'd0,  30'd0};
        vt[1]  = '{1'b0, 1'b1, 30'd1,  1'b0, 1'b1, 1'b0, 17'd0,  30'd0};
        vt[2]  = '{1'b0, 1'b1, 30'd2,  1'b0, 1'b1, 1'b1, 17'd0,  30'd1};
        vt[3]  = '{1'b0, 1'b1, 30'd3,  1'b0, 1'b1, 1'b1, 17'd1,  30'd2};
        vt[4]  = '{1'b0, 1'b1, 30'd4,  1'b0, 1'b1, 1'b1, 17'd2,  30'd3};
        vt[5]  = '{1'b0, 1'b1, 30'd5,  1'b0, 1'b1, 1'b1, 17'd3,  30'd4};
        vt[6]  = '{1'b0, 1'b1, 30'd6,  1'b0, 1'b1, 1'b1, 17'd4,  30'd5};
        vt[7]  = '{1'b0, 1'b1, 30'd7,  1'b0, 1'b1, 1'b1, 17'd5,  30'd6};
        vt[8]  = '{1'b0, 1'b1, 30'd8,  1'b0, 1'b1, 1'b1, 17'd6,  30'd7};
        vt[9]  = '{1'b0, 1'b0, 30'd0,  1'b0, 1'b1, 1'b1, 17'd7,  30'd8};
        vt[10] = '{1'b0, 1'b0, 30'd0,  1'b0, 1'b1, 1'b0, 17'd7,  30'd8};
        vt[11] = '{1'b0, 1'b1, 30'd9,  1'b0, 1'b1, 1'b0, 17'd7,  30'd8};
        vt[12] = '{1'b0, 1'b1, 30'd10, 1'b0, 1'b1, 1'b1, 17'd8,  30'd9};
        vt[13] = '{1'b0, 1'b1, 30'd11, 1'b1, 1'b0, 1'b1, 17'd8,  30'd9};
        vt[14] = '{1'b0, 1'b1, 30'd12, 1'b1, 1'b0, 1'b1, 17'd8,  30'd9};
        vt[15] = '{1'b0, 1'b1, 30'd12, 1'b1, 1'b0, 1'b1, 17'd8,  30'd9};
        vt[16] = '{1'b0, 1'b1, 30'd12, 1'b1, 1'b0, 1'b1, 17'd8,  30'd9};
        vt[17] = '{1'b0, 1'b1, 30'd12, 1'b1, 1'b0, 1'b1, 17'd8,  30'd9};
        vt[18] = '{1'b0, 1'b1, 30'd12, 1'b0, 1'b1, 1'b1, 17'd9,  30'd10};
        vt[19] = '{1'b0, 1'b1, 30'd12, 1'b0, 1'b1, 1'b1, 17'd10, 30'd11};
        vt[20] = '{1'b0, 1'b0, 30'd0,  1'b0, 1'b1, 1'b1, 17'd11, 30'd12};
        vt[21] = '{1'b0, 1'b0, 30'd0,  1'b0, 1'b1, 1'b0, 17'd11, 30'd12};

        step();
        for (int i = 0; i < 22; i++) begin
            frame_start = vt[i].fs;
            x_valid     = vt[i].vld;
            x_data      = vt[i].data;
            wr_busy     = vt[i].busy;
            step();
            check($sformatf("v%0d_ready", i), 32'(x_ready), 32'(vt[i].e_rdy));
            check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vt[i].e_en));
            check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vt[i].e_addr));
            check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vt[i].e_data));
        end
        frame_start = 1'b0;
        x_valid = 1'b0;
        wr_busy = 1'b0;

        // Asynchronous reset mid-frame with a write pending
        wr_busy = 1'b1;
        send_px(30'h1111);
        send_px(30'h2222);
        step();
        check("pre_reset_wr_en", 32'(wr_en), 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 0);
        check("async_rst_wr_addr", 32'(wr_addr), 0);
        check("async_rst_wr_data", 32'(wr_data), 0);
        check("async_rst_ready", 32'(x_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_busy = 1'b0;
        x_valid = 1'b1;
        x_data = 30'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_ready_%0d", i), 32'(x_ready), 0);
            check($sformatf("idle_wr_en_%0d", i), 32'(wr_en), 0);
        end
        // frame_start in IDLE while valid: no handshake that cycle
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        x_valid = 1'b0;
        check("ready_after_fs", 32'(x_ready), 1);
        step();
        check("idle_fs_no_capture_0", 32'(wr_en), 0);
        step();
        check("idle_fs_no_capture_1", 32'(wr_en), 0);

        // Full frame at one pixel per clock
        errs = 0;
        done_cnt = 0;
        done_at = -1;
        for (int c = 0; c <= int'(N) + 1; c++) begin
            if (c < int'(N)) begin
                x_valid = 1'b1;
                x_data  = pix(c);
            end else begin
                x_valid = 1'b0;
            end
            step();
            if (frame_done) begin
                done_cnt++;
                done_at = c;
            end
            if (c >= 1 && c <= int'(N)) begin
                if (!wr_en || wr_addr != 17'(c - 1) || wr_data != pix(c - 1) || !x_ready)
                    errs++;
            end
            if (c == 320) check("row_boundary_addr_319", 32'(wr_addr), 319);
            if (c == 321) check("row_boundary_addr_320", 32'(wr_addr), 320);
            if (c == int'(N)) check("last_addr", 32'(wr_addr), N - 1);
        end
        check("frame_write_errs", 32'(errs), 0);
        check("frame_done_count", 32'(done_cnt), 1);
        check("frame_done_cycle", 32'(done_at), N + 1);
        check("frame_sync_err", 32'(sync_err), 0);

        // frame_start exactly at the frame boundary
        pulse_fs();
        check("boundary_fs_sync_err", 32'(sync_err), 0);
        send_px(30'h1234);
        step();
        check("new_frame_wr_en", 32'(wr_en), 1);
        check("new_frame_addr", 32'(wr_addr), 0);
        check("new_frame_data", 32'(wr_data), 32'h1234);

        // frame_start together with a handshake of 0xABCDE
        frame_start = 1'b1;
        x_valid = 1'b1;
        x_data = 30'hABCDE;
        step();
        frame_start = 1'b0;
        x_valid = 1'b0;
        check("coinc_sync_err", 32'(sync_err), 1);
        check("coinc_wr_en_drop", 32'(wr_en), 0);
        step();
        check("coinc_wr_en", 32'(wr_en), 1);
        check("coinc_addr", 32'(wr_addr), 0);
        check("coinc_data", 32'(wr_data), 32'hABCDE);
        step();
        check("coinc_no_extra", 32'(wr_en), 0);

        // frame_start after 100 pixels with a stalled write and a full FIFO
        do_reset();
        check("reset_clears_sync_err", 32'(sync_err), 0);
        pulse_fs();
        for (int i = 0; i < 100; i++) send_px(30'(32'h1000 + i));
        step();
        check("px99_addr", 32'(wr_addr), 99);
        check("px99_data", 32'(wr_data), 32'h1000 + 99);
        step();
        check("px100_sync_err", 32'(sync_err), 0);
        wr_busy = 1'b1;
        send_px(30'hAAA);
        send_px(30'hBBB);
        send_px(30'hCCC);
        check("stalled_ready", 32'(x_ready), 0);
        check("stalled_addr", 32'(wr_addr), 100);
        pulse_fs();
        check("mid_fs_sync_err", 32'(sync_err), 1);
        check("mid_fs_wr_en", 32'(wr_en), 0);
        check("mid_fs_ready", 32'(x_ready), 1);
        wr_busy = 1'b0;
        send_px(30'h777);
        step();
        check("resync_wr_en", 32'(wr_en), 1);
        check("resync_addr", 32'(wr_addr), 0);
        check("resync_data", 32'(wr_data), 32'h777);
        step();
        check("fifo_flushed", 32'(wr_en), 0);
        check("sync_err_sticky", 32'(sync_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
